mvu_pe_simd_acc_binary: RTL and testbench

//  SIMD-wide bipolar multiply plus adder tree plus fold accumulator for one MVAU processing element.

---
 rtl/mvu_pe_simd_acc_binary.sv | 101 ++++++++++
 tb/tb_mvu_pe_simd_acc_binary.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mvu_pe_simd_acc_binary.sv
// mvu_pe_simd_acc_binary: SIMD bipolar/XNOR lane products, adder tree
// and fold accumulator for one MVAU processing element.
module mvu_pe_simd_acc_binary #(
    parameter int SIMD  = 4,
    parameter int TSrcI = 4,
    parameter int TW    = 1,
    parameter int TDstI = 16,
    parameter int SF    = 8,
    parameter int MODE  = 0
) (
    input  logic                  aclk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  in_v,
    input  logic [SIMD*TSrcI-1:0] in_act,
    input  logic [SIMD*TW-1:0]    in_wgt,
    output logic                  out_v,
    output logic [TDstI-1:0]      out
);
    localparam int XW = (MODE == 1) ? TW : TSrcI;
    localparam int PW = XW + 1;
    localparam int SW = PW + $clog2(SIMD);
    localparam int CW = (SF > 1) ? $clog2(SF) : 1;

    logic [PW-1:0]           lane_d [SIMD];
    logic [PW-1:0]           lane_q [SIMD];
    logic                    v1;
    logic                    v2;
    logic                    vq;
    logic signed [SW-1:0]    sum_d;
    logic signed [SW-1:0]    sum_q;
    logic signed [TDstI-1:0] sum_ext;
    logic [TDstI-1:0]        acc;
    logic [TDstI-1:0]        acc_nxt;
    logic [CW-1:0]           cnt;

    for (genvar i = 0; i < SIMD; i++) begin : g_lane
        if (MODE == 2) begin : g_xnor
            assign lane_d[i] = {{(PW-1){1'b0}},
                                ~(in_act[i*TSrcI] ^ in_wgt[i*TW])};
        end else begin : g_bip
            logic [XW-1:0] x;
            logic          b;
            logic [PW-1:0] xe;
            if (MODE == 1) begin : g_m1
                assign x = in_wgt[i*TW +: TW];
                assign b = in_act[i*TSrcI];
            end else begin : g_m0
                assign x = in_act[i*TSrcI +: TSrcI];
                assign b = in_wgt[i*TW];
            end
            // One extra bit so negating the most negative value cannot wrap
            assign xe        = {x[XW-1], x};
            assign lane_d[i] = b ? xe : (~xe + PW'(1));
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < SIMD; i++) begin
            sum_d = sum_d + SW'(signed'(lane_q[i]));
        end
    end

    assign sum_ext = TDstI'(sum_q);
    assign acc_nxt = (cnt == '0) ? sum_ext : (acc + sum_ext);
    assign out_v   = vq & ce;

    always_ff @(posedge aclk) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            vq    <= 1'b0;
            sum_q <= '0;
            acc   <= '0;
            cnt   <= '0;
            out   <= '0;
            for (int i = 0; i < SIMD; i++) begin
                lane_q[i] <= '0;
            end
        end else if (ce) begin
            v1 <= in_v;
            for (int i = 0; i < SIMD; i++) begin
                lane_q[i] <= lane_d[i];
            end
            v2    <= v1;
            sum_q <= sum_d;
            vq    <= 1'b0;
            if (v2) begin
                acc <= acc_nxt;
                if (cnt == CW'(SF - 1)) begin
                    out <= acc_nxt;
                    vq  <= 1'b1;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_mvu_pe_simd_acc_binary.sv
// tb_mvu_pe_simd_acc_binary: directed vectors for the SIMD bipolar
// accumulator across MODE0/MODE2, SF=1/2/4 and a narrow wrapping output.
module tb_mvu_pe_simd_acc_binary;
    logic clk = 1'b0;
    logic rst;
    logic ce;
    always #5 clk = ~clk;

    logic        v0, v1, v2, v3;
    logic [15:0] act0, act1, act3;
    logic [3:0]  act2;
    logic [3:0]  wgt0, wgt1, wgt2, wgt3;
    logic        ov0, ov1, ov2, ov3;
    logic [15:0] o0, o1, o2;
    logic [5:0]  o3;

    int n_chk  = 0;
    int n_fail = 0;

    mvu_pe_simd_acc_binary #(.SIMD(4), .TSrcI(4), .TW(1), .TDstI(16),
        .SF(2), .MODE(0)) u0 (
        .aclk(clk), .rst(rst), .ce(ce), .in_v(v0), .in_act(act0),
        .in_wgt(wgt0), .out_v(ov0), .out(o0));

    mvu_pe_simd_acc_binary #(.SIMD(4), .TSrcI(4), .TW(1), .TDstI(16),
        .SF(1), .MODE(0)) u1 (
        .aclk(clk), .rst(rst), .ce(ce), .in_v(v1), .in_act(act1),
        .in_wgt(wgt1), .out_v(ov1), .out(o1));

    mvu_pe_simd_acc_binary #(.SIMD(4), .TSrcI(1), .TW(1), .TDstI(16),
        .SF(2), .MODE(2)) u2 (
        .aclk(clk), .rst(rst), .ce(ce), .in_v(v2), .in_act(act2),
        .in_wgt(wgt2), .out_v(ov2), .out(o2));

    mvu_pe_simd_acc_binary #(.SIMD(4), .TSrcI(4), .TW(1), .TDstI(6),
        .SF(4), .MODE(0)) u3 (
        .aclk(clk), .rst(rst), .ce(ce), .in_v(v3), .in_act(act3),
        .in_wgt(wgt3), .out_v(ov3), .out(o3));

    typedef struct {
        string       name;
        logic [15:0] a1;
        logic [3:0]  w1;
        logic [15:0] a2;
        logic [3:0]  w2;
        int          exp;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        vecs[0] = '{"t1",    16'h87E3, 4'b1010, 16'h1111, 4'b1111, -16};
        vecs[1] = '{"neg8",  16'h8888, 4'b0000, 16'h8888, 4'b0000, 64};
        vecs[2] = '{"cancel",16'h7777, 4'b1111, 16'h7777, 4'b0000, 0};
        vecs[3] = '{"mixed", 16'h1234, 4'b0101, 16'hF0F0, 4'b0000, 4};

        rst = 1'b1; ce = 1'b1;
        v0 = 0; v1 = 0; v2 = 0; v3 = 0;
        act0 = '0; act1 = '0; act2 = '0; act3 = '0;
        wgt0 = '0; wgt1 = '0; wgt2 = '0; wgt3 = '0;
        tick();
        tick();
        check("rst_ov0", ov0, 0);
        check("rst_o0", $signed(o0), 0);
        check("rst_ov3", ov3, 0);
        check("rst_o3", $signed(o3), 0);
        rst = 1'b0;
        tick();

        // Two-beat folds on u0: pulse exactly 3 edges after beat2 is driven
        for (int k = 0; k < 4; k++) begin
            v0 = 1; act0 = vecs[k].a1; wgt0 = vecs[k].w1;
            tick();
            act0 = vecs[k].a2; wgt0 = vecs[k].w2;
            tick();
            v0 = 0;
            check({vecs[k].name, "_v1"}, ov0, 0);
            tick();
            check({vecs[k].name, "_v2"}, ov0, 0);
            tick();
            check({vecs[k].name, "_v3"}, ov0, 1);
            check({vecs[k].name, "_out"}, $signed(o0), vecs[k].exp);
            tick();
            check({vecs[k].name, "_v4"}, ov0, 0);
            check({vecs[k].name, "_hold"}, $signed(o0), vecs[k].exp);
        end

        // T2: SF=1, back-to-back beats, -8 negation without wrap
        v1 = 1; act1 = 16'h8888; wgt1 = 4'b0000;
        tick();
        act1 = 16'h1111; wgt1 = 4'b1111;
        tick();
        v1 = 0;
        check("t2_early", ov1, 0);
        tick();
        check("t2_v_a", ov1, 1);
        check("t2_out_a", $signed(o1), 32);
        tick();
        check("t2_v_b", ov1, 1);
        check("t2_out_b", $signed(o1), 4);
        tick();
        check("t2_v_end", ov1, 0);
        check("t2_hold", $signed(o1), 4);

        // T3: XNOR popcount
        v2 = 1; act2 = 4'b1100; wgt2 = 4'b1010;
        tick();
        act2 = 4'b1111; wgt2 = 4'b1111;
        tick();
        v2 = 0;
        check("t3_early", ov2, 0);
        tick();
        tick();
        check("t3_v", ov2, 1);
        check("t3_out", $signed(o2), 6);
        tick();
        check("t3_v_end", ov2, 0);

        // T4: ce low for two cycles while the fold sits in S2
        v0 = 1; act0 = 16'h87E3; wgt0 = 4'b1010;
        tick();
        act0 = 16'h1111; wgt0 = 4'b1111;
        tick();
        v0 = 0;
        tick();
        check("t4_pre", ov0, 0);
        ce = 0;
        tick();
        check("t4_stall1", ov0, 0);
        tick();
        check("t4_stall2", ov0, 0);
        ce = 1;
        tick();
        check("t4_v", ov0, 1);
        check("t4_out", $signed(o0), -16);
        tick();
        check("t4_nodup", ov0, 0);

        // T5: reset mid-fold discards beat A
        v0 = 1; act0 = 16'h0005; wgt0 = 4'b0001;
        tick();
        v0 = 0; rst = 1;
        tick();
        check("t5_rst_v", ov0, 0);
        check("t5_rst_out", $signed(o0), 0);
        rst = 0;
        v0 = 1; act0 = 16'h0001; wgt0 = 4'b0001;
        tick();
        check("t5_v_a", ov0, 0);
        act0 = 16'h0002; wgt0 = 4'b0001;
        tick();
        v0 = 0;
        check("t5_v_b", ov0, 0);
        tick();
        check("t5_v_c", ov0, 0);
        tick();
        check("t5_v", ov0, 1);
        check("t5_out", $signed(o0), 3);

        // T6: 4 x 31 with bubbles wraps to -4 in 6 bits
        act3 = 16'h7888; wgt3 = 4'b1000;
        begin
            logic [6:0] pat;
            pat = 7'b1100101;
            for (int i = 0; i < 7; i++) begin
                v3 = pat[i];
                tick();
                check("t6_quiet", ov3, 0);
            end
        end
        v3 = 0;
        tick();
        check("t6_v_a", ov3, 0);
        tick();
        check("t6_v", ov3, 1);
        check("t6_out", $signed(o3), -4);
        tick();
        check("t6_v_end", ov3, 0);
        check("t6_hold", $signed(o3), -4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
